gray_rx_decoder: RTL and testbench

//  Downstream consumer of the bing binary-to-Gray stage. Samples a Gray-coded bus

---
 rtl/gray_rx_decoder_if.sv | 56 +++++
 rtl/gray_rx_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_gray_rx_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/gray_rx_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_rx_decoder_if
// Description : Bus bundle between a Gray-code source and gray_rx_decoder.
//               master : drives G and clr_err, observes decoded outputs
//               slave  : the decoder (receives G/clr_err, drives outputs)
// Signals     : G        [WIDTH] Gray code from the upstream stage
//               clr_err  [1]     synchronous clear of step_err
//               B        [WIDTH] registered decoded binary
//               B_valid  [1]     one-cycle pulse when B reloads
//               dir      [1]     1 = last legal step was +1, 0 = -1
//               step_err [1]     sticky multi-bit-jump flag
//               step_cnt [16]    legal step count (GRAY_RX_STEP_CNT_EN only)
// Config      : GRAY_RX_STEP_CNT_EN adds step_cnt
// Revision    : 1.0  initial release
// ============================================================================
interface gray_rx_decoder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] G;
    logic             clr_err;
    logic [WIDTH-1:0] B;
    logic             B_valid;
    logic             dir;
    logic             step_err;
`ifdef GRAY_RX_STEP_CNT_EN
    logic [15:0]      step_cnt;
`endif

    modport master (
        output G,
        output clr_err,
        input  B,
        input  B_valid,
        input  dir,
        input  step_err
`ifdef GRAY_RX_STEP_CNT_EN
        ,
        input  step_cnt
`endif
    );

    modport slave (
        input  G,
        input  clr_err,
        output B,
        output B_valid,
        output dir,
        output step_err
`ifdef GRAY_RX_STEP_CNT_EN
        ,
        output step_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/gray_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray_rx_decoder
// Description : Samples an unsynchronised Gray-coded bus through a flop
//               chain, decodes it to binary, pulses B_valid on every
//               change, reports step direction and flags illegal
//               multi-bit Gray jumps with a sticky error.
// Ports       : clk          rising-edge clock
//               rst          asynchronous active-high reset
//               bus (slave)  G, clr_err in; B, B_valid, dir, step_err out
//                            (+ step_cnt when GRAY_RX_STEP_CNT_EN is defined)
// Parameters  : WIDTH        Gray/binary width (>= 2)
//               SYNC_STAGES  synchroniser depth on G (>= 2)
// Config      : GRAY_RX_STEP_CNT_EN  enables 16-bit saturating count of
//               legal single-bit steps
// Revision    : 1.0  initial release
// ============================================================================
module gray_rx_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    gray_rx_decoder_if.slave bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("gray_rx_decoder: WIDTH must be >= 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("gray_rx_decoder: SYNC_STAGES must be >= 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] c_fill_last = CNT_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_b_one     = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PRIME = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Gray -> binary: each binary bit is the XOR of all Gray bits at or
    // above it, built as a running XOR from the MSB down.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_g_prev;
    logic [WIDTH-1:0] r_b;
    logic             r_b_valid;
    logic             r_dir;
    logic             r_step_err;
    state_t           r_state;
    logic [CNT_W-1:0] r_fill_cnt;

    // ------------------------------------------------------------------------
    // Combinational decode / compare
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_g_sync;
    logic [WIDTH-1:0] w_decoded;
    logic [WIDTH-1:0] w_b_inc;
    int unsigned      w_dist;

    assign w_g_sync  = r_sync[SYNC_STAGES-1];
    assign w_decoded = gray2bin(w_g_sync);
    // Width-limited increment so max+1 wraps to 0 and max->0 reads as +1.
    assign w_b_inc   = r_b + c_b_one;
    assign w_dist    = popcount(w_g_sync ^ r_g_prev);

    // ------------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.G;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_fill_cnt_nxt;
    logic             w_load;
    logic             w_legal_step;
    logic             w_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and datapath controls
    // FILL waits until the chain holds only post-reset samples, so the value
    // jump across a reset is absorbed by PRIME rather than flagged.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_load         = 1'b0;
        w_legal_step   = 1'b0;
        w_jump         = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (r_fill_cnt == c_fill_last) begin
                    w_state_nxt = ST_PRIME;
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + c_cnt_one;
                end
            end
            ST_PRIME: begin
                w_load      = 1'b1;
                w_state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (w_dist == 1) begin
                    w_load       = 1'b1;
                    w_legal_step = 1'b1;
                end else if (w_dist >= 2) begin
                    w_load = 1'b1;
                    w_jump = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_FILL;
                w_fill_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g_prev   <= '0;
            r_b        <= '0;
            r_b_valid  <= 1'b0;
            r_dir      <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            r_b_valid <= w_load;
            if (w_load) begin
                r_g_prev <= w_g_sync;
                r_b      <= w_decoded;
            end
            // A legal step is either +1 or -1, so "not +1" means -1.
            if (w_legal_step) begin
                r_dir <= (w_decoded == w_b_inc);
            end
            // A new jump has priority over a coincident clear.
            if (w_jump) begin
                r_step_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_step_err <= 1'b0;
            end
        end
    end

    assign bus.B        = r_b;
    assign bus.B_valid  = r_b_valid;
    assign bus.dir      = r_dir;
    assign bus.step_err = r_step_err;

`ifdef GRAY_RX_STEP_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating count of legal single-bit steps; clear beats a same-cycle
    // step.
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_cnt_max = 16'hFFFF;
    logic [15:0] r_step_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= '0;
        end else if (bus.clr_err) begin
            r_step_cnt <= '0;
        end else if (w_legal_step && (r_step_cnt != c_cnt_max)) begin
            r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    assign bus.step_cnt = r_step_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_rx_decoder
// Description : Directed self-checking bench for gray_rx_decoder
//               (WIDTH=4, SYNC_STAGES=2). Inputs change 1 time unit after
//               a rising edge; outputs are sampled at the same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gray_rx_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gray_rx_decoder_if #(.WIDTH(4)) bus ();

    gray_rx_decoder #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    // Apply a new G and wait the three edges it takes to reach B.
    task automatic apply(input logic [3:0] g);
        bus.G = g;
        tick();
        tick();
        tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.G       = 4'b0110;
        bus.clr_err = 1'b0;

        // ---- 1: reset state and priming latency -----------------------------
        #3;
        check("rst_B",        16'(bus.B),        16'h0);
        check("rst_B_valid",  16'(bus.B_valid),  16'h0);
        check("rst_dir",      16'(bus.dir),      16'h0);
        check("rst_step_err", 16'(bus.step_err), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t1_e1_valid", 16'(bus.B_valid), 16'h0);
        tick();
        check("t1_e2_valid", 16'(bus.B_valid), 16'h0);
        check("t1_e2_B",     16'(bus.B),       16'h0);
        tick();
        check("t1_e3_B",     16'(bus.B),        16'h4);
        check("t1_e3_valid", 16'(bus.B_valid),  16'h1);
        check("t1_e3_err",   16'(bus.step_err), 16'h0);
        tick();
        check("t1_e4_valid", 16'(bus.B_valid), 16'h0);

        // ---- 2: count up 0..15 ----------------------------------------------
        rst   = 1'b1;
        bus.G = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t2_prime_B",     16'(bus.B),       16'h0);
        check("t2_prime_valid", 16'(bus.B_valid), 16'h1);
        repeat (7) tick();
        for (int v = 1; v < 16; v++) begin
            bus.G = gray(v);
            tick();
            tick();
            check("t2_lat_valid", 16'(bus.B_valid), 16'h0);
            check("t2_lat_B",     16'(bus.B),       16'(v - 1));
            tick();
            check("t2_B",     16'(bus.B),       16'(v));
            check("t2_valid", 16'(bus.B_valid), 16'h1);
            check("t2_dir",   16'(bus.dir),     16'h1);
            tick();
            check("t2_pulse_end", 16'(bus.B_valid), 16'h0);
            repeat (6) tick();
        end
        check("t2_err", 16'(bus.step_err), 16'h0);
`ifdef GRAY_RX_STEP_CNT_EN
        check("t2_step_cnt", bus.step_cnt, 16'd15);
`endif

        // ---- 3: wrap-around -------------------------------------------------
        apply(4'b0000);
        check("t3_up_B",   16'(bus.B),   16'h0);
        check("t3_up_dir", 16'(bus.dir), 16'h1);
        apply(4'b1000);
        check("t3_dn_B",   16'(bus.B),        16'hF);
        check("t3_dn_dir", 16'(bus.dir),      16'h0);
        check("t3_err",    16'(bus.step_err), 16'h0);

        // ---- 4: illegal jump and clear --------------------------------------
        apply(4'b0000);
        check("t4_pre_dir", 16'(bus.dir), 16'h1);
`ifdef GRAY_RX_STEP_CNT_EN
        check("t4_step_cnt", bus.step_cnt, 16'd18);
`endif
        apply(4'b0011);
        check("t4_B",     16'(bus.B),        16'h2);
        check("t4_valid", 16'(bus.B_valid),  16'h1);
        check("t4_err",   16'(bus.step_err), 16'h1);
        check("t4_dir",   16'(bus.dir),      16'h1);
        tick();
        check("t4_err_sticky", 16'(bus.step_err), 16'h1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("t4_clr", 16'(bus.step_err), 16'h0);
`ifdef GRAY_RX_STEP_CNT_EN
        check("t4_cnt_clr", bus.step_cnt, 16'd0);
`endif

        // ---- 5: clear coinciding with a jump --------------------------------
        bus.G = 4'b0000;
        tick();
        tick();
        check("t5_pre_err", 16'(bus.step_err), 16'h0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("t5_err_wins", 16'(bus.step_err), 16'h1);
        check("t5_B",        16'(bus.B),        16'h0);
        tick();
        check("t5_err_hold", 16'(bus.step_err), 16'h1);

        // ---- 6: asynchronous reset mid-stream -------------------------------
        apply(4'b1111);
        check("t6_pre_B",   16'(bus.B),        16'hA);
        check("t6_pre_dir", 16'(bus.dir),      16'h1);
        check("t6_pre_err", 16'(bus.step_err), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_B",     16'(bus.B),        16'h0);
        check("t6_async_valid", 16'(bus.B_valid),  16'h0);
        check("t6_async_dir",   16'(bus.dir),      16'h0);
        check("t6_async_err",   16'(bus.step_err), 16'h0);
        bus.G = 4'b0101;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t6_e2_valid", 16'(bus.B_valid), 16'h0);
        tick();
        check("t6_B",     16'(bus.B),        16'h6);
        check("t6_valid", 16'(bus.B_valid),  16'h1);
        check("t6_err",   16'(bus.step_err), 16'h0);
        repeat (3) tick();
        check("t6_err_after", 16'(bus.step_err), 16'h0);
        check("t6_B_hold",    16'(bus.B),        16'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
